// File: rtl/eeprom_pkg.sv
// Shared constants and state encoding for the EEPROM burst controller.
package eeprom_pkg;

  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [3:0] DEV_ID   = 4'b1010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_WAITDATA,
    S_W_ISSUE,
    S_W_BUSY,
    S_W_TWR,
    S_R_ISSUE,
    S_R_BUSY,
    S_R_DRAIN,
    S_DONE
  } state_t;

  // 7-bit I2C device address from the chip-select strap bits.
  function automatic logic [6:0] dev_addr(input logic [2:0] chip);
    return {DEV_ID, chip};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 256
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_push,
  input  logic [P_WIDTH-1:0]                 i_data,
  input  logic                               i_pop,
  output logic [P_WIDTH-1:0]                 o_data,
  output logic [$clog2(P_DEPTH+1)-1:0]       o_count
);

  localparam int unsigned AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int unsigned CW = $clog2(P_DEPTH + 1);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               empty, full, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(P_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Push/pop qualification and pointer/count update.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(P_DEPTH));
    do_pop   = i_pop && !empty;
    do_push  = i_push && (!full || do_pop);
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers; reset flushes the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/eeprom_burst_ctrl.sv
// Splits user read/write bursts into page-safe I2C EEPROM driver commands.
module eeprom_burst_ctrl
  import eeprom_pkg::*;
#(
  parameter int unsigned P_ADDR_BYTES = 2,
  parameter int unsigned P_PAGE_SIZE  = 32,
  parameter int unsigned P_FIFO_DEPTH = 256,
  parameter int unsigned P_TWR_CYCLES = 250000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_eeprom_addr,
  input  logic [15:0] i_user_operation_addr,
  input  logic [1:0]  i_user_operation_type,
  input  logic [7:0]  i_user_operation_len,
  input  logic        i_user_operation_valid,
  output logic        o_user_operation_ready,
  input  logic [7:0]  i_user_write_data,
  input  logic        i_user_write_valid,
  output logic [7:0]  o_user_read_data,
  output logic        o_user_read_valid,
  input  logic        i_user_read_ready,
  output logic        o_user_done,
  output logic [6:0]  o_device_addr,
  output logic [15:0] o_operation_addr,
  output logic [7:0]  o_operation_len,
  output logic [1:0]  o_operation_type,
  output logic        o_operation_valid,
  input  logic        i_operation_ready,
  output logic [7:0]  o_write_data,
  input  logic        i_write_req,
  input  logic [7:0]  i_read_data,
  input  logic        i_read_valid
);

  localparam int unsigned PB = $clog2(P_PAGE_SIZE);
  localparam int unsigned CW = $clog2(P_FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(P_TWR_CYCLES + 1);
  localparam logic [TW-1:0] TWR_LAST = TW'(P_TWR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  rem_q, rem_d, len_q, len_d;
  logic [2:0]  chip_q, chip_d;
  logic [8:0]  chunk_q, chunk_d, chunk, page_room;
  logic [TW-1:0] twr_cnt_q, twr_cnt_d;
  logic [8:0]  rx_cnt_q, rx_cnt_d;
  logic        rdy_q, drv_end, load_wr;
  logic        op_valid_q, op_valid_d;
  logic [6:0]  op_dev_q, op_dev_d;
  logic [15:0] op_addr_q, op_addr_d;
  logic [7:0]  op_len_q, op_len_d;
  logic [1:0]  op_type_q, op_type_d;
  logic [CW-1:0] wf_count, rf_count;
  logic        rf_empty;

  function automatic logic [15:0] mask_addr(input logic [15:0] a);
    return (P_ADDR_BYTES == 1) ? {8'h00, a[7:0]} : a;
  endfunction

  sync_fifo #(.P_WIDTH(8), .P_DEPTH(P_FIFO_DEPTH)) u_wr_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(i_user_write_valid), .i_data(i_user_write_data),
    .i_pop(i_write_req), .o_data(o_write_data), .o_count(wf_count)
  );

  sync_fifo #(.P_WIDTH(8), .P_DEPTH(P_FIFO_DEPTH)) u_rd_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(i_read_valid), .i_data(i_read_data),
    .i_pop(i_user_read_ready), .o_data(o_user_read_data), .o_count(rf_count)
  );

  // Page-bounded chunk for the next write command and driver-end detection.
  always_comb begin
    page_room = 9'(P_PAGE_SIZE) - 9'(addr_q[PB-1:0]);
    chunk     = (9'(rem_q) < page_room) ? 9'(rem_q) : page_room;
    drv_end   = i_operation_ready && !rdy_q;
    rf_empty  = (rf_count == '0);
  end

  // Next-state and command-register logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    chip_d     = chip_q;
    chunk_d    = chunk_q;
    twr_cnt_d  = twr_cnt_q;
    rx_cnt_d   = i_read_valid ? rx_cnt_q + 9'd1 : rx_cnt_q;
    op_valid_d = op_valid_q;
    op_dev_d   = op_dev_q;
    op_addr_d  = op_addr_q;
    op_len_d   = op_len_q;
    op_type_d  = op_type_q;
    load_wr    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_user_operation_valid) begin
          addr_d   = i_user_operation_addr;
          rem_d    = i_user_operation_len;
          len_d    = i_user_operation_len;
          chip_d   = i_eeprom_addr;
          rx_cnt_d = '0;
          if (i_user_operation_len == 8'd0) begin
            state_d = S_DONE;
          end else if (i_user_operation_type == OP_WRITE) begin
            state_d = S_W_WAITDATA;
          end else if (i_user_operation_type == OP_READ) begin
            state_d    = S_R_ISSUE;
            op_valid_d = 1'b1;
            op_dev_d   = dev_addr(i_eeprom_addr);
            op_addr_d  = mask_addr(i_user_operation_addr);
            op_len_d   = i_user_operation_len;
            op_type_d  = OP_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_W_WAITDATA: if (wf_count >= CW'(rem_q)) load_wr = 1'b1;
      S_W_ISSUE, S_R_ISSUE: begin
        if (op_valid_q && i_operation_ready) begin
          op_valid_d = 1'b0;
          state_d    = (state_q == S_W_ISSUE) ? S_W_BUSY : S_R_BUSY;
        end
      end
      S_W_BUSY: begin
        if (drv_end) begin
          addr_d    = addr_q + 16'(chunk_q);
          rem_d     = rem_q - 8'(chunk_q);
          twr_cnt_d = '0;
          state_d   = S_W_TWR;
        end
      end
      S_W_TWR: begin
        if (twr_cnt_q == TWR_LAST) begin
          if (rem_q != 8'd0) load_wr = 1'b1;
          else               state_d = S_DONE;
        end else begin
          twr_cnt_d = twr_cnt_q + TW'(1);
        end
      end
      S_R_BUSY:  if (drv_end) state_d = S_R_DRAIN;
      S_R_DRAIN: if (rf_empty && rx_cnt_q == 9'(len_q)) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (load_wr) begin
      state_d    = S_W_ISSUE;
      chunk_d    = chunk;
      op_valid_d = 1'b1;
      op_dev_d   = dev_addr(chip_q);
      op_addr_d  = mask_addr(addr_q);
      op_len_d   = 8'(chunk);
      op_type_d  = OP_WRITE;
    end
  end

  // State and command registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      chip_q     <= '0;
      chunk_q    <= '0;
      twr_cnt_q  <= '0;
      rx_cnt_q   <= '0;
      rdy_q      <= 1'b0;
      op_valid_q <= 1'b0;
      op_dev_q   <= '0;
      op_addr_q  <= '0;
      op_len_q   <= '0;
      op_type_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      chip_q     <= chip_d;
      chunk_q    <= chunk_d;
      twr_cnt_q  <= twr_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rdy_q      <= i_operation_ready;
      op_valid_q <= op_valid_d;
      op_dev_q   <= op_dev_d;
      op_addr_q  <= op_addr_d;
      op_len_q   <= op_len_d;
      op_type_q  <= op_type_d;
    end
  end

  assign o_user_operation_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_user_done            = (state_q == S_DONE);
  assign o_user_read_valid      = !rf_empty;
  assign o_operation_valid      = op_valid_q;
  assign o_device_addr          = op_dev_q;
  assign o_operation_addr       = op_addr_q;
  assign o_operation_len        = op_len_q;
  assign o_operation_type       = op_type_q;

endmodule

// File: doc/eeprom_burst_ctrl.md
EEPROM_BURST_CTRL -- requirements
Module: eeprom_burst_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  P_ADDR_BYTES 2: EEPROM word-address bytes (1 or 2); 1 forces o_operation_addr[15:8]=0.
  P_PAGE_SIZE 32: EEPROM page size in bytes; power of 2, 8..256.
  P_FIFO_DEPTH 256: depth of each data FIFO; must be >=256.
  P_TWR_CYCLES 250000: internal write-cycle wait, in clocks.
REQ-002 Ports (name direction width meaning), one per line:
  i_clk in 1: the single clock; one clock domain.
  i_rst in 1: reset, synchronous, active-high.
  i_eeprom_addr in 3: chip-select bits A2..A0.
  i_user_operation_addr in 16: start byte address.
  i_user_operation_type in 2: 1 = write, 2 = read.
  i_user_operation_len in 8: byte count.
  i_user_operation_valid in 1 / o_user_operation_ready out 1: command handshake.
  i_user_write_data in 8 / i_user_write_valid in 1: write-data push.
  o_user_read_data out 8 / o_user_read_valid out 1 / i_user_read_ready in 1: read-data stream.
  o_user_done out 1: one-cycle pulse when a command completes.
  o_device_addr out 7, o_operation_addr out 16, o_operation_len out 8, o_operation_type out 2, o_operation_valid out 1, i_operation_ready in 1: I2C driver command.
  o_write_data out 8, i_write_req in 1: driver pulls write bytes.
  i_read_data in 8, i_read_valid in 1: driver pushes read bytes.

Function
REQ-003 Command accepted when valid and ready are both high; address, type, len and chip bits are captured; ready drops the next cycle and stays low until the command's done pulse.
REQ-004 States: IDLE, W_WAITDATA, W_ISSUE, W_BUSY, W_TWR, R_ISSUE, R_BUSY, R_DRAIN, DONE; DONE lasts exactly one cycle and raises o_user_done and ready.
REQ-005 Type not in {1,2}, or len=0: IDLE -> DONE, no driver command issued.
REQ-006 Write data is pushed into the write FIFO at any time, 1 byte per valid cycle; W_WAITDATA -> W_ISSUE when FIFO count >= remaining length.
REQ-007 Write chunk = min(remaining, P_PAGE_SIZE - (addr mod P_PAGE_SIZE)); a write never crosses a page boundary.
REQ-008 W_ISSUE drives the driver command: device {4'b1010, chip}, current addr, chunk, type 1, valid=1. Valid is held until valid and ready are both high, then cleared the next cycle.
REQ-009 Driver end = rising edge of i_operation_ready after the accepted command. W_BUSY -> W_TWR; addr += chunk (16-bit wrap 0xFFFF->0x0000); remaining -= chunk.
REQ-010 W_TWR counts P_TWR_CYCLES clocks, then goes to W_ISSUE if remaining > 0, else DONE.
REQ-011 i_write_req pops the write FIFO; o_write_data is the FIFO head (first-word-fall-through).
REQ-012 Read: R_ISSUE issues one sequential read with the full len and type 2; R_BUSY -> R_DRAIN on driver end.
REQ-013 Each i_read_valid pushes i_read_data into the read FIFO; the output is AXI-stream-like, popped on valid and ready both high. Data and valid are held stable while ready is low.
REQ-014 R_DRAIN -> DONE when read FIFO is empty and received count = len. Fewer bytes from the driver hang the block in R_DRAIN until reset.
REQ-015 Simultaneous push and pop on one FIFO: count unchanged and data order preserved. A push while full is dropped (impossible under REQ-001); a pop while empty is ignored.
REQ-016 Command valid is ignored while ready is low; write-data pushes are always accepted.

Reset
REQ-017 i_rst, at any state or mid-transfer, returns the block to IDLE within 1 cycle and flushes both FIFOs. Output values under reset: o_user_operation_ready=1; all other outputs 0.
REQ-018 A driver end arriving after reset is ignored.

Structure
REQ-019 Shared package eeprom_pkg holds the type codes (W=1, R=2), the device-ID constant 4'b1010 and the state encoding.
REQ-020 One sub-module, sync_fifo (parametrised width/depth, first-word-fall-through, count output), instantiated twice; the vendor FIFO IP is not used.

Verification
REQ-021 Write addr 0x001C, len 10, page 32 -> driver commands (0x001C,4) then (0x0020,6), a P_TWR_CYCLES gap after each, one done pulse.
REQ-022 Write addr 0x0000, len 64 -> two 32-byte commands at 0x0000 and 0x0020; bytes 0..63 delivered in order on i_write_req.
REQ-023 Read addr 0x0100, len 200, i_user_read_ready toggled 50% -> one driver command (0x0100,200), 200 bytes out in order, none lost, done after the last byte.
REQ-024 Write addr 0xFFFE, len 4, page 32 -> commands (0xFFFE,2) then (0x0000,2).
REQ-025 Reset asserted mid-W_TWR -> ready=1 the next cycle, FIFO empty, no further driver command.
REQ-026 len=0 or type=3 -> done 1 cycle after acceptance, o_operation_valid never asserted.
